multicycle_mips: RTL and testbench

MULTICYCLE_MIPS -- requirements
Module: multicycle_mips

---
 rtl/multicycle_mips.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_multicycle_mips.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mips.sv
// Multicycle MIPS subset core: lw, sw, R-type, beq, addi, j on one shared ALU
// and one shared instruction/data memory port, one FSM step per cycle.
module multicycle_mips #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter bit          WAIT_STATES_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] adr,
  output logic [31:0] writedata,
  output logic        memwrite,
  output logic        memread,
  input  logic [31:0] readdata,
  input  logic        memready,
  output logic [3:0]  state_dbg
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } aluctl_t;

  // ALU B-operand and PC source selectors
  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  state_t state, state_next;

  logic [XLEN-1:0] pc, ir, mdr, a, b, aluout;
  logic [XLEN-1:0] rf [32];

  logic [5:0]        op, funct;
  logic [RIDX_W-1:0] rs, rt, rd;
  logic [XLEN-1:0]   simm;
  logic              ready;
  logic              funct_known;

  // control
  logic            iord, ir_we, pc_we, pc_we_cond, mdr_we, ab_we, aluout_we;
  logic            rf_we, regdst_rd, memtoreg, alusrca_a;
  logic            rd_strobe, wr_strobe;
  logic [1:0]      alusrcb, pcsrc;
  aluctl_t         aluctl;

  logic [XLEN-1:0]   alu_x, alu_y, alu_r, pc_next, rf_a, rf_b, rf_wd;
  logic [RIDX_W-1:0] rf_wa;
  logic              alu_zero;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign simm  = {{16{ir[15]}}, ir[15:0]};
  assign ready = WAIT_STATES_EN ? memready : 1'b1;

  assign funct_known = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                       (funct == FN_OR)  || (funct == FN_SLT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:  if (ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (ready) state_next = S_MEMWB;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   if (ready) state_next = S_FETCH;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_RTYPEWB: state_next = S_FETCH;
      S_BEQEX:   state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // Control outputs per state
  always_comb begin
    iord       = 1'b0;
    rd_strobe  = 1'b0;
    wr_strobe  = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_we_cond = 1'b0;
    mdr_we     = 1'b0;
    ab_we      = 1'b0;
    aluout_we  = 1'b0;
    rf_we      = 1'b0;
    regdst_rd  = 1'b0;
    memtoreg   = 1'b0;
    alusrca_a  = 1'b0;
    alusrcb    = SRCB_FOUR;
    pcsrc      = PCSRC_ALU;
    aluctl     = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        rd_strobe = 1'b1;
        ir_we     = ready;
        pc_we     = ready;
      end
      S_DECODE: begin
        ab_we     = 1'b1;
        alusrcb   = SRCB_IMMSH;
        aluout_we = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_a = 1'b1;
        alusrcb   = SRCB_IMM;
        aluout_we = 1'b1;
      end
      S_MEMRD: begin
        iord      = 1'b1;
        rd_strobe = 1'b1;
        mdr_we    = ready;
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        wr_strobe = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_a = 1'b1;
        alusrcb   = SRCB_B;
        aluout_we = 1'b1;
        case (funct)
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_SLT:  aluctl = ALU_SLT;
          default: aluctl = ALU_ADD;
        endcase
      end
      S_RTYPEWB: begin
        rf_we     = funct_known;
        regdst_rd = 1'b1;
      end
      S_BEQEX: begin
        alusrca_a  = 1'b1;
        alusrcb    = SRCB_B;
        aluctl     = ALU_SUB;
        pc_we_cond = 1'b1;
        pcsrc      = PCSRC_ALUOUT;
      end
      S_ADDIWB: rf_we = 1'b1;
      S_JUMP: begin
        pc_we = 1'b1;
        pcsrc = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  // Memory port; reset silences both strobes in the same cycle
  assign memread   = rd_strobe & ~reset;
  assign memwrite  = wr_strobe & ~reset;
  assign adr       = iord ? aluout : pc;
  assign writedata = b;
  assign state_dbg = 4'(state);

  // Shared ALU
  always_comb begin
    alu_x = alusrca_a ? a : pc;
    unique case (alusrcb)
      SRCB_B:    alu_y = b;
      SRCB_FOUR: alu_y = XLEN'(4);
      SRCB_IMM:  alu_y = simm;
      default:   alu_y = {simm[XLEN-3:0], 2'b00};
    endcase
    unique case (aluctl)
      ALU_SUB: alu_r = alu_x - alu_y;
      ALU_AND: alu_r = alu_x & alu_y;
      ALU_OR:  alu_r = alu_x | alu_y;
      ALU_SLT: alu_r = XLEN'($signed(alu_x) < $signed(alu_y));
      default: alu_r = alu_x + alu_y;
    endcase
  end

  assign alu_zero = (alu_r == '0);

  always_comb begin
    unique case (pcsrc)
      PCSRC_ALUOUT: pc_next = aluout;
      PCSRC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      default:      pc_next = alu_r;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      if (ir_we)     ir     <= readdata;
      if (mdr_we)    mdr    <= readdata;
      if (aluout_we) aluout <= alu_r;
      if (ab_we) begin
        a <= rf_a;
        b <= rf_b;
      end
      if (pc_we || (pc_we_cond && alu_zero)) pc <= pc_next;
    end
  end

  // Register file: $0 reads as zero, writes to it are dropped, contents survive reset
  assign rf_a  = (rs == '0) ? '0 : rf[rs];
  assign rf_b  = (rt == '0) ? '0 : rf[rt];
  assign rf_wa = regdst_rd ? rd : rt;
  assign rf_wd = memtoreg ? mdr : aluout;

  always_ff @(posedge clk) begin
    if (rf_we && !reset && (rf_wa != '0)) rf[rf_wa] <= rf_wd;
  end

endmodule

// File: tb/tb_multicycle_mips.sv
// Directed bench for multicycle_mips: runs a small program from a bench-held
// memory and checks bus activity at hand-computed cycle numbers.
module tb_multicycle_mips;

  logic        clk = 1'b0;
  logic        reset;
  logic        memready;
  logic [31:0] adr, writedata, readdata;
  logic        memwrite, memread;
  logic [3:0]  state_dbg;

  logic [31:0] mem [256];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nstores = 0;
  logic [3:0] st_fetch;

  multicycle_mips dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .memread   (memread),
    .readdata  (readdata),
    .memready  (memready),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  assign readdata = mem[adr[9:2]];

  always @(posedge clk) begin
    if (memwrite && memready) nstores <= nstores + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge; strobes must stay exclusive
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("rd_wr_exclusive", {31'b0, memread & memwrite}, 32'd0);
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h2002_0005; // addi $2,$0,5
    mem[1]   = 32'h2003_000C; // addi $3,$0,12
    mem[2]   = 32'h0043_2020; // add  $4,$2,$3
    mem[3]   = 32'hAC04_0054; // sw   $4,84($0)
    mem[4]   = 32'h1000_0002; // beq  $0,$0,+2
    mem[7]   = 32'h1043_0005; // beq  $2,$3,+5 (not taken)
    mem[8]   = 32'h2001_0001; // addi $1,$0,1
    mem[9]   = 32'h0001_3022; // sub  $6,$0,$1
    mem[10]  = 32'h00C1_382A; // slt  $7,$6,$1
    mem[11]  = 32'h2000_0007; // addi $0,$0,7
    mem[12]  = 32'h0000_2820; // add  $5,$0,$0
    mem[13]  = 32'hAC06_0180; // sw   $6,0x180($0)
    mem[14]  = 32'hAC07_0184; // sw   $7,0x184($0)
    mem[15]  = 32'hAC05_0188; // sw   $5,0x188($0)
    mem[16]  = 32'h8C08_0200; // lw   $8,0x200($0)
    mem[17]  = 32'hAC08_018C; // sw   $8,0x18C($0)
    mem[18]  = 32'hFC00_0000; // unknown opcode
    mem[19]  = 32'h0800_0040; // j    0x40 -> 0x100
    mem[64]  = 32'hAC04_0110; // sw   $4,0x110($0)
    mem[128] = 32'hDEAD_BEEF;

    reset    = 1'b1;
    memready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_memread", {31'b0, memread}, 32'd0);
    chk("reset_memwrite", {31'b0, memwrite}, 32'd0);

    reset = 1'b0;
    #1;
    cyc = 1;
    chk("first_fetch_adr", adr, 32'h0);
    chk("first_fetch_memread", {31'b0, memread}, 32'd1);
    chk("first_fetch_memwrite", {31'b0, memwrite}, 32'd0);
    st_fetch = state_dbg;

    go_to(2);
    chk("decode_memread", {31'b0, memread}, 32'd0);
    chk("decode_state_moves", {31'b0, state_dbg !== st_fetch}, 32'd1);

    go_to(16);
    chk("sw84_memwrite", {31'b0, memwrite}, 32'd1);
    chk("sw84_adr", adr, 32'd84);
    chk("sw84_data", writedata, 32'd17);
    chk("sw84_memread", {31'b0, memread}, 32'd0);

    go_to(17);
    chk("beq_fetch_adr", adr, 32'h10);
    go_to(20);
    chk("beq_taken_adr", adr, 32'h1C);
    chk("beq_taken_memread", {31'b0, memread}, 32'd1);
    go_to(23);
    chk("beq_not_taken_adr", adr, 32'h20);

    go_to(46);
    chk("sub_store_adr", adr, 32'h180);
    chk("sub_result", writedata, 32'hFFFF_FFFF);
    go_to(50);
    chk("slt_store_adr", adr, 32'h184);
    chk("slt_result", writedata, 32'd1);
    go_to(54);
    chk("r0_store_adr", adr, 32'h188);
    chk("r0_result", writedata, 32'd0);
    chk("r0_memwrite", {31'b0, memwrite}, 32'd1);

    // lw with three wait cycles in MEMRD (cycles 58..60)
    go_to(57);
    memready = 1'b0;
    go_to(58);
    chk("lw_rd_adr", adr, 32'h200);
    chk("lw_rd_memread", {31'b0, memread}, 32'd1);
    go_to(60);
    chk("lw_wait_adr", adr, 32'h200);
    chk("lw_wait_memread", {31'b0, memread}, 32'd1);
    go_to(61);
    memready = 1'b1;
    chk("lw_last_wait_adr", adr, 32'h200);
    go_to(62);
    chk("lw_wb_memread", {31'b0, memread}, 32'd0);
    go_to(63);
    chk("after_lw_fetch_adr", adr, 32'h44);
    go_to(66);
    chk("lw_store_adr", adr, 32'h18C);
    chk("lw_result", writedata, 32'hDEAD_BEEF);

    go_to(69);
    chk("nop_fetch_adr", adr, 32'h4C);
    go_to(72);
    chk("jump_fetch_adr", adr, 32'h100);
    chk("jump_fetch_memread", {31'b0, memread}, 32'd1);

    // Store stalled by memready=0, then killed by reset
    go_to(74);
    memready = 1'b0;
    go_to(75);
    chk("stall_sw_memwrite", {31'b0, memwrite}, 32'd1);
    chk("stall_sw_adr", adr, 32'h110);
    chk("stall_sw_data", writedata, 32'd17);
    go_to(76);
    chk("stall_sw_held", {31'b0, memwrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_in_memwr_memwrite", {31'b0, memwrite}, 32'd0);
    chk("reset_in_memwr_memread", {31'b0, memread}, 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    memready = 1'b1;
    #1;
    chk("post_reset_adr", adr, 32'h0);
    chk("post_reset_memread", {31'b0, memread}, 32'd1);
    chk("post_reset_memwrite", {31'b0, memwrite}, 32'd0);
    chk("post_reset_state", {28'b0, state_dbg}, {28'b0, st_fetch});
    chk("store_count", 32'(nstores), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
